pipelined_rca: RTL and testbench

PIPELINED_RCA -- requirements
Module: pipelined_rca

---
 rtl/pipelined_rca_pkg.sv | 30 +++
 rtl/rca_slice.sv | 29 ++
 rtl/pipelined_rca.sv | 127 ++++++++++++
 tb/tb_pipelined_rca.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Holds default sizing, the per-stage record layout and a carry-in helper.
package pipelined_rca_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Control part of a stage record; width independent.
    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
        logic ovf;
    } stage_ctl_t;

    // Full stage record at the default width: control, partial sum, and
    // the operands still to be consumed by later stages.
    typedef struct packed {
        stage_ctl_t               ctl;
        logic [DEF_WIDTH-1:0]     sum;
        logic [DEF_WIDTH-1:0]     a;
        logic [DEF_WIDTH-1:0]     b;
    } stage_t;

    // Subtraction is a + ~b + 1, so the first slice sees a forced carry.
    function automatic logic carry_in(input logic sub, input logic cin);
        return sub ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational ripple-carry slice of W bits.
// Ports: a, b, cin in; sum, cout, carry_msb (carry into the top bit) out.
module rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         carry_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout      = c[W];
    assign carry_msb = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract with valid/ready flow control.
// Ports: clk, rst (async high); in_valid/in_ready, a, b, cin, sub;
// out_valid/out_ready, sum, cout (1 = no borrow on sub), ovf (signed).
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;

    if (WIDTH < 2) begin : g_bad_width
        $error("pipelined_rca: WIDTH must be at least 2");
    end

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_split
        $error("pipelined_rca: WIDTH must be a multiple of STAGES");
    end

    // Stage k holds an operation whose bits [0 .. (k+1)*SLICE-1] are done.
    // Operands travel with it so later slices need no input skew buffer.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_ctl_t       ctl_q;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic             take;

        logic             src_valid;
        logic             src_sub;
        logic             src_carry;
        logic [WIDTH-1:0] src_sum;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;

        logic [SLICE-1:0] sl_b;
        logic [SLICE-1:0] sl_sum;
        logic             sl_co;
        logic             sl_cm;
        logic [WIDTH-1:0] nxt_sum;

        if (k == 0) begin : g_src
            assign src_valid = in_valid;
            assign src_sub   = sub;
            assign src_carry = carry_in(sub, cin);
            assign src_sum   = '0;
            assign src_a     = a;
            assign src_b     = b;
        end else begin : g_src
            assign src_valid = g_stage[k-1].ctl_q.valid;
            assign src_sub   = g_stage[k-1].ctl_q.sub;
            assign src_carry = g_stage[k-1].ctl_q.carry;
            assign src_sum   = g_stage[k-1].sum_q;
            assign src_a     = g_stage[k-1].a_q;
            assign src_b     = g_stage[k-1].b_q;
        end

        // Inversion is done per slice so the raw b can ride along.
        assign sl_b = src_sub ? ~src_b[k*SLICE +: SLICE]
                              :  src_b[k*SLICE +: SLICE];

        rca_slice #(
            .W(SLICE)
        ) u_slice (
            .a        (src_a[k*SLICE +: SLICE]),
            .b        (sl_b),
            .cin      (src_carry),
            .sum      (sl_sum),
            .cout     (sl_co),
            .carry_msb(sl_cm)
        );

        always_comb begin
            nxt_sum                   = src_sum;
            nxt_sum[k*SLICE +: SLICE] = sl_sum;
        end

        // A stage loads when it is empty or its content moves on;
        // this chains back from the output so bubbles collapse.
        if (k == STAGES - 1) begin : g_take
            assign take = !ctl_q.valid || out_ready;
        end else begin : g_take
            assign take = !ctl_q.valid || g_stage[k+1].take;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctl_q <= '0;
                sum_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
            end else if (take) begin
                ctl_q.valid <= src_valid;
                ctl_q.sub   <= src_sub;
                ctl_q.carry <= sl_co;
                // Only meaningful in the last stage, where the slice
                // contains the MSB.
                ctl_q.ovf   <= sl_co ^ sl_cm;
                sum_q       <= nxt_sum;
                a_q         <= src_a;
                b_q         <= src_b;
            end
        end
    end

    assign in_ready  = !rst && g_stage[0].take;
    assign out_valid = g_stage[STAGES-1].ctl_q.valid;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].ctl_q.carry;
    assign ovf       = g_stage[STAGES-1].ctl_q.ovf;

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca (WIDTH=16, STAGES=4).
// Random and directed traffic checked against an arithmetic model.
module tb_pipelined_rca;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q[$];

    pipelined_rca #(
        .WIDTH (16),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, {ovf, cout, sum}.
    function automatic logic [17:0] ref_op(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic c,
                                           input logic s);
        int ux, uy, sx, sy, u, r;
        logic co, ov;
        logic [15:0] res;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            co  = (ux >= uy);
            u   = ux - uy + 65536;
            r   = sx - sy;
        end else begin
            u   = ux + uy + int'(c);
            co  = (u >= 65536);
            r   = sx + sy + int'(c);
        end
        res = 16'(u % 65536);
        ov  = (r > 32767) || (r < -32768);
        return {ov, co, res};
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drive at the falling edge, sample handshake and outputs 1ns later.
    task automatic drive_cycle(input logic iv, input logic [15:0] x,
                               input logic [15:0] y, input logic c,
                               input logic s, input logic ordy,
                               output logic acc, output logic del,
                               output logic ovld, output logic [15:0] rs,
                               output logic rco, output logic rov,
                               output logic irdy);
        @(negedge clk);
        in_valid  = iv;
        a         = x;
        b         = y;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #1;
        acc  = in_valid && in_ready;
        del  = out_valid && out_ready;
        ovld = out_valid;
        rs   = sum;
        rco  = cout;
        rov  = ovf;
        irdy = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        total++;
        if ({ovf, cout, sum} !== 18'h0) begin
            bad++;
            $display("FAIL rst_data: got ovf=%b cout=%b sum=%h want 0",
                     ovf, cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va[3] = '{16'hFFFF, 16'h7FFF, 16'h0005};
        logic [15:0] vb[3] = '{16'h0001, 16'h0001, 16'h0007};
        logic        vs[3] = '{1'b0, 1'b0, 1'b1};
        logic [17:0] ve[3] = '{{1'b0, 1'b1, 16'h0000},
                               {1'b1, 1'b0, 16'h8000},
                               {1'b0, 1'b0, 16'hFFFE}};
        logic acc, del, ovld, rco, rov, irdy;
        logic [15:0] rs;
        int lat;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, va[i], vb[i], 1'b0, vs[i], 1'b1,
                        acc, del, ovld, rs, rco, rov, irdy);
            total++;
            if (!acc) begin
                bad++;
                $display("FAIL vec%0d_accept: in_ready=%b want 1", i, irdy);
            end
            lat = 0;
            for (int n = 1; n <= 12 && lat == 0; n++) begin
                drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1,
                            acc, del, ovld, rs, rco, rov, irdy);
                if (ovld) begin
                    lat = n;
                    total++;
                    if ({rov, rco, rs} !== ve[i]) begin
                        bad++;
                        $display("FAIL vec%0d_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 i, rov, rco, rs, ve[i][17], ve[i][16], ve[i][15:0]);
                    end
                end
            end
            total++;
            if (lat != 4) begin
                bad++;
                $display("FAIL vec%0d_latency: got %0d want 4 (0 = timeout)", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc, del, ovld, rco, rov, irdy, iv, ordy, c, s, hold, full_seen;
        logic [15:0] rs, x, y;
        logic [17:0] held, e;
        int sent, got;
        sent = 0;
        got = 0;
        hold = 1'b0;
        held = '0;
        full_seen = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            iv   = (sent < 8);
            ordy = !(cyc >= 2 && cyc < 8);
            x    = pick_operand();
            y    = pick_operand();
            c    = 1'($urandom);
            s    = 1'($urandom);
            drive_cycle(iv, x, y, c, s, ordy, acc, del, ovld, rs, rco, rov, irdy);
            if (hold) begin
                total++;
                if (!ovld || {rov, rco, rs} !== held) begin
                    bad++;
                    $display("FAIL bp_stable: got v=%b %h want v=1 %h",
                             ovld, {rov, rco, rs}, held);
                end
            end
            hold = ovld && !ordy;
            held = {rov, rco, rs};
            total++;
            if (irdy !== !(exp_q.size() == 4 && !ordy)) begin
                bad++;
                $display("FAIL bp_in_ready: got %b with %0d held, out_ready=%b",
                         irdy, exp_q.size(), ordy);
            end
            if (!irdy) full_seen = 1'b1;
            if (del) begin
                total++;
                got++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: got sum=%h want none", rs);
                end else begin
                    e = exp_q.pop_front();
                    if ({rov, rco, rs} !== e) begin
                        bad++;
                        $display("FAIL bp_result: got %h want %h", {rov, rco, rs}, e);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(ref_op(x, y, c, s));
                sent++;
            end
        end
        total++;
        if (sent != 8 || got != 8 || !full_seen) begin
            bad++;
            $display("FAIL bp_count: got sent=%0d recv=%0d full=%b want 8 8 1",
                     sent, got, full_seen);
        end
        exp_q.delete();
    endtask

    task automatic test_mixed();
        logic acc, del, ovld, rco, rov, irdy, c, s;
        logic [15:0] rs, x, y;
        logic [17:0] e;
        int sent, got;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 40; cyc++) begin
            x = pick_operand();
            y = pick_operand();
            s = sent[0];
            c = sent[1];
            drive_cycle(sent < 40, x, y, c, s, 1'b1,
                        acc, del, ovld, rs, rco, rov, irdy);
            total++;
            if (irdy !== 1'b1) begin
                bad++;
                $display("FAIL mix_in_ready: got %b want 1", irdy);
            end
            if (del) begin
                total++;
                got++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mix_extra: got sum=%h want none", rs);
                end else begin
                    e = exp_q.pop_front();
                    if ({rov, rco, rs} !== e) begin
                        bad++;
                        $display("FAIL mix_result: got %h want %h", {rov, rco, rs}, e);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(ref_op(x, y, c, s));
                sent++;
            end
        end
        total++;
        if (got != 40) begin
            bad++;
            $display("FAIL mix_count: got %0d want 40", got);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic acc, del, ovld, rco, rov, irdy, iv, ordy, c, s, hold;
        logic [15:0] rs, x, y;
        logic [17:0] held, e;
        int sent, got;
        sent = 0;
        got = 0;
        hold = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 330; cyc++) begin
            if (cyc >= 300 && exp_q.size() == 0) break;
            iv   = (cyc < 300) && ($urandom_range(0, 9) < 7);
            ordy = (cyc >= 300) || ($urandom_range(0, 9) < 6);
            x    = pick_operand();
            y    = pick_operand();
            c    = 1'($urandom);
            s    = 1'($urandom);
            drive_cycle(iv, x, y, c, s, ordy, acc, del, ovld, rs, rco, rov, irdy);
            if (hold) begin
                total++;
                if (!ovld || {rov, rco, rs} !== held) begin
                    bad++;
                    $display("FAIL rnd_stable: got v=%b %h want v=1 %h",
                             ovld, {rov, rco, rs}, held);
                end
            end
            hold = ovld && !ordy;
            held = {rov, rco, rs};
            total++;
            if (irdy !== !(exp_q.size() == 4 && !ordy)) begin
                bad++;
                $display("FAIL rnd_in_ready: got %b with %0d held, out_ready=%b",
                         irdy, exp_q.size(), ordy);
            end
            if (del) begin
                total++;
                got++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra: got sum=%h want none", rs);
                end else begin
                    e = exp_q.pop_front();
                    if ({rov, rco, rs} !== e) begin
                        bad++;
                        $display("FAIL rnd_result: got %h want %h", {rov, rco, rs}, e);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(ref_op(x, y, c, s));
                sent++;
            end
        end
        total++;
        if (exp_q.size() != 0 || got != sent) begin
            bad++;
            $display("FAIL rnd_drain: got recv=%0d left=%0d want recv=%0d left=0",
                     got, exp_q.size(), sent);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_inflight();
        logic acc, del, ovld, rco, rov, irdy;
        logic [15:0] rs;
        int n_acc;
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 16'(16'h1111 * (i + 1)), 16'h0101, 1'b1, 1'b0, 1'b0,
                        acc, del, ovld, rs, rco, rov, irdy);
            if (acc) n_acc++;
        end
        repeat (2) drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0,
                               acc, del, ovld, rs, rco, rov, irdy);
        total++;
        if (n_acc != 3 || !ovld) begin
            bad++;
            $display("FAIL rif_setup: got accepted=%0d out_valid=%b want 3 1",
                     n_acc, ovld);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rif_async: got out_valid=%b in_ready=%b want 0 0",
                     out_valid, in_ready);
        end
        total++;
        if ({ovf, cout, sum} !== 18'h0) begin
            bad++;
            $display("FAIL rif_data: got %h want 0", {ovf, cout, sum});
        end
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rif_release_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1,
                        acc, del, ovld, rs, rco, rov, irdy);
            total++;
            if (ovld !== 1'b0) begin
                bad++;
                $display("FAIL rif_stale: got out_valid=1 sum=%h want 0", rs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_mixed();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
